// File: rtl/input_loader_pkg.sv
// Shared constants, FSM encoding and address helper for the input loader.
package input_loader_pkg;

    localparam int BA    = 8;
    localparam int N     = 40;
    localparam int BM    = 6;
    localparam int DEPTH = 128;
    localparam int BC    = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    localparam logic [BM-1:0] ADDR_LAST = BM'(N - 1);

    typedef enum logic [1:0] {
        LD_IDLE   = 2'd0,
        LD_STREAM = 2'd1,
        LD_ZFILL  = 2'd2,
        LD_DONE   = 2'd3
    } ld_state_t;

    // Word index within a vector, wrapping after N-1.
    function automatic logic [BM-1:0] addr_next(input logic [BM-1:0] a);
        return (a == ADDR_LAST) ? '0 : a + BM'(1);
    endfunction

endpackage

// File: rtl/input_loader_if.sv
// Sample stream into the loader: valid/ready handshake plus vector-boundary marker.
interface input_loader_if;
    import input_loader_pkg::*;

    logic [BA-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;

    modport master (output s_data, output s_valid, output s_last, input s_ready);
    modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/input_loader_sync_fifo.sv
// Sample buffer: synchronous FIFO with first-word-fall-through head.
// Latency: a pushed word is visible at head the cycle after the push.
// Backpressure: full when count == DEPTH; push ignored while full, even in a pop cycle.
module input_loader_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/input_loader.sv
// Buffers samples and issues one N-word vector (data+addr) per request_in rise; LOADER_LAST_CHECK_EN adds s_last framing check.
// Latency: first valid_out 1 cycle after request rise, N consecutive words, vec_done the cycle after.
// Backpressure: s_ready = !fifo_full; a request with fewer than N words buffered emits zeros and flags underrun.
module input_loader
    import input_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input_loader_if.slave       s,
    input  logic                request_in,
    output logic [BA-1:0]       data_out,
    output logic [BM-1:0]       addr_out,
    output logic                valid_out,
    output logic                vec_done,
    output logic                underrun,
    output logic                frame_err,
    output logic [BC-1:0]       vec_count
);

    ld_state_t     state_q, state_d;
    logic          request_in_q;
    logic          req_rise;
    logic          pop;
    logic          fifo_full;
    logic          unused_empty;
    logic [BA-1:0] fifo_head;
    logic [CW-1:0] fifo_count;

    logic [BA-1:0] data_d;
    logic [BM-1:0] addr_d;
    logic          valid_d;
    logic          done_d;
    logic          underrun_set;

    assign req_rise  = request_in && !request_in_q;
    assign s.s_ready = !fifo_full;

    input_loader_sync_fifo #(.W(BA), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s.s_valid),
        .push_data (s.s_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (unused_empty),
        .count     (fifo_count)
    );

    // Outputs are computed one state ahead so that the request-rise edge already
    // presents word 0; addr_out itself serves as the in-vector word counter.
    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        valid_d      = 1'b0;
        data_d       = '0;
        addr_d       = '0;
        done_d       = 1'b0;
        underrun_set = 1'b0;
        case (state_q)
            LD_IDLE: begin
                if (req_rise) begin
                    valid_d = 1'b1;
                    if (fifo_count >= CW'(N)) begin
                        state_d = LD_STREAM;
                        pop     = 1'b1;
                        data_d  = fifo_head;
                    end else begin
                        state_d      = LD_ZFILL;
                        underrun_set = 1'b1;
                    end
                end
            end
            LD_STREAM: begin
                if (addr_out == ADDR_LAST) begin
                    state_d = LD_DONE;
                    done_d  = 1'b1;
                end else begin
                    pop     = 1'b1;
                    valid_d = 1'b1;
                    data_d  = fifo_head;
                    addr_d  = addr_next(addr_out);
                end
            end
            LD_ZFILL: begin
                if (addr_out == ADDR_LAST) begin
                    state_d = LD_DONE;
                    done_d  = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    addr_d  = addr_next(addr_out);
                end
            end
            LD_DONE: state_d = LD_IDLE;
            default: state_d = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LD_IDLE;
            request_in_q <= 1'b0;
            data_out     <= '0;
            addr_out     <= '0;
            valid_out    <= 1'b0;
            vec_done     <= 1'b0;
            underrun     <= 1'b0;
            vec_count    <= '0;
        end else begin
            state_q      <= state_d;
            request_in_q <= request_in;
            data_out     <= data_d;
            addr_out     <= addr_d;
            valid_out    <= valid_d;
            vec_done     <= done_d;
            if (underrun_set) underrun  <= 1'b1;
            if (done_d)       vec_count <= vec_count + BC'(1);
        end
    end

`ifdef LOADER_LAST_CHECK_EN
    logic [BM-1:0] push_pos;
    logic          push_acc;

    assign push_acc = s.s_valid && s.s_ready;

    // s_last must mark exactly the word landing at vector position N-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            push_pos  <= '0;
            frame_err <= 1'b0;
        end else if (push_acc) begin
            push_pos <= addr_next(push_pos);
            if (s.s_last != (push_pos == ADDR_LAST)) frame_err <= 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = s.s_last;
    assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_input_loader.sv
// Scoreboard bench for input_loader: stimulus queues expected words, a negedge monitor checks them.
module tb_input_loader;
    import input_loader_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          request_in = 1'b0;
    logic [BA-1:0] data_out;
    logic [BM-1:0] addr_out;
    logic          valid_out;
    logic          vec_done;
    logic          underrun;
    logic          frame_err;
    logic [BC-1:0] vec_count;

    input_loader_if lif();

    input_loader dut (
        .clk        (clk),
        .rst        (rst),
        .s          (lif),
        .request_in (request_in),
        .data_out   (data_out),
        .addr_out   (addr_out),
        .valid_out  (valid_out),
        .vec_done   (vec_done),
        .underrun   (underrun),
        .frame_err  (frame_err),
        .vec_count  (vec_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BA-1:0] d;
        logic [BM-1:0] a;
    } exp_t;

    exp_t          sb[$];
    logic [BA-1:0] model[$];
    int            total = 0;
    int            bad = 0;
    int            push_pos = 0;
    int            exp_vec = 0;
    logic          exp_under = 1'b0;
    logic          pend_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every valid word must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pend_done = 1'b0;
        end else begin
            if (pend_done) begin
                check("vec_done", vec_done, 1);
                pend_done = 1'b0;
            end
            if (valid_out) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", valid_out, 0);
                end else begin
                    e = sb.pop_front();
                    check("data_out", data_out, e.d);
                    check("addr_out", addr_out, e.a);
                    if (e.a == ADDR_LAST) pend_done = 1'b1;
                end
            end else begin
                check("idle_data", data_out, 0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_words(input int first, input int n, input int bad_last_idx);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            lif.s_data  = 8'(first + i);
            lif.s_last  = (i == bad_last_idx) ? 1'b1 : (push_pos == N - 1);
            lif.s_valid = 1'b1;
            while (!lif.s_ready && g < 500) begin
                tick();
                g++;
            end
            if (g >= 500) check("push_timeout", lif.s_ready, 1);
            tick();
            model.push_back(8'(first + i));
            push_pos = (push_pos + 1) % N;
        end
        lif.s_valid = 1'b0;
        lif.s_last  = 1'b0;
    endtask

    task automatic request(input bit retrigger);
        if (model.size() >= N) begin
            for (int a = 0; a < N; a++) sb.push_back('{model.pop_front(), 6'(a)});
        end else begin
            exp_under = 1'b1;
            for (int a = 0; a < N; a++) sb.push_back('{8'd0, 6'(a)});
        end
        exp_vec++;
        request_in = 1'b1;
        tick();
        request_in = 1'b0;
        if (retrigger) begin
            repeat (5) tick();
            request_in = 1'b1;
            tick();
            request_in = 1'b0;
        end
    endtask

    task automatic wait_vec();
        int g = 0;
        while (sb.size() != 0 && g < 200) begin
            tick();
            g++;
        end
        check("vec_timeout", sb.size(), 0);
        tick();
        tick();
        check("vec_count", vec_count, exp_vec);
        check("underrun", underrun, exp_under);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int g;
        lif.s_data  = '0;
        lif.s_valid = 1'b0;
        lif.s_last  = 1'b0;
        repeat (3) tick();
        check("rst_data", data_out, 0);
        check("rst_addr", addr_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_done", vec_done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_vec_count", vec_count, 0);
        check("rst_s_ready", lif.s_ready, 1);
        rst = 1'b0;
        tick();

        // 1: full vector 1..40
        push_words(1, 40, -1);
        request(0);
        wait_vec();

        // 2: underrun with 10 buffered; mid-vector re-rise ignored; the 10 words survive
        push_words(101, 10, -1);
        request(1);
        wait_vec();
        push_words(111, 30, -1);
        request(0);
        wait_vec();

        // 3: fill to DEPTH, refused push while full, ready returns after first pop
        push_words(1, DEPTH, -1);
        check("s_ready_full", lif.s_ready, 0);
        lif.s_data  = 8'hEE;
        lif.s_valid = 1'b1;
        repeat (3) tick();
        lif.s_valid = 1'b0;
        request(0);
        check("s_ready_after_pop", lif.s_ready, 1);
        wait_vec();

        // 4: push during stream keeps count at 88, so exactly 40 more fit
        request(0);
        push_words(200, 40, -1);
        wait_vec();
        acc = 0;
        for (int k = 0; k < 60; k++) begin
            if (!lif.s_ready) break;
            push_words(acc, 1, -1);
            acc++;
        end
        check("fill_room", acc, 40);
        request(0);
        wait_vec();

        // 5: reset at addr 20 of a stream
        request(0);
        g = 0;
        while (g < 100) begin
            @(negedge clk);
            if (valid_out && addr_out == 6'd20) break;
            g++;
        end
        check("reach_addr20", addr_out, 20);
        rst = 1'b1;
        sb.delete();
        model.delete();
        push_pos  = 0;
        exp_vec   = 0;
        exp_under = 1'b0;
        tick();
        check("mid_rst_valid", valid_out, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_addr", addr_out, 0);
        check("mid_rst_vec_count", vec_count, 0);
        check("mid_rst_underrun", underrun, 0);
        check("mid_rst_s_ready", lif.s_ready, 1);
        rst = 1'b0;
        tick();
        push_words(50, 40, -1);
        request(0);
        wait_vec();
        check("frame_err_aligned", frame_err, 0);

        // 6: s_last on the 39th word
        push_words(1, 40, 38);
        tick();
`ifdef LOADER_LAST_CHECK_EN
        check("frame_err_misaligned", frame_err, 1);
`else
        check("frame_err_misaligned", frame_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
